// File: rtl/ulpi_tx_arbiter.sv
// ULPI link-side transmit controller: arbitrates PHY register writes and packet
// transmits onto the link-driven half of the ULPI bus and sequences CMD/DATA/STP.
module ulpi_tx_arbiter #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_stp,
    input  logic       reg_req,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_gnt,
    output logic       reg_done,
    input  logic       pkt_req,
    input  logic [3:0] pkt_pid,
    input  logic [7:0] pkt_data,
    input  logic       pkt_valid,
    input  logic       pkt_last,
    output logic       pkt_gnt,
    output logic       pkt_rd,
    output logic       pkt_done,
    output logic       abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_STOP,
        S_ABORT,
        S_BUSY,
        S_TURN
    } state_t;

    // Handshakes: a byte on ulpi_data_out is taken by the PHY in any cycle with
    // ulpi_nxt=1; a payload byte is consumed (pkt_rd) only when pkt_valid=1 in
    // that same cycle. Requests stay high until their done pulse or abort.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_pkt_q, sel_pkt_d;  // current / most recent grant: 1 = pkt

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_pkt_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_pkt_q <= sel_pkt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        sel_pkt_d     = sel_pkt_q;
        ulpi_data_out = 8'h00;
        ulpi_stp      = 1'b0;
        reg_gnt       = 1'b0;
        pkt_gnt       = 1'b0;
        reg_done      = 1'b0;
        pkt_done      = 1'b0;
        pkt_rd        = 1'b0;
        abort         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ulpi_dir) begin
                    state_d = S_BUSY;
                end else if (reg_req || pkt_req) begin
                    // On a tie, serve whoever did not have the bus last time.
                    sel_pkt_d = (reg_req && pkt_req) ? ~sel_pkt_q : pkt_req;
                    state_d   = S_CMD;
                end
            end

            S_CMD: begin
                reg_gnt       = ~sel_pkt_q;
                pkt_gnt       = sel_pkt_q;
                ulpi_data_out = sel_pkt_q ? {4'b0100, pkt_pid} : {2'b10, reg_addr};
                if (ulpi_dir) begin
                    abort   = 1'b1;
                    state_d = S_BUSY;
                end else if (ulpi_nxt) begin
                    state_d = S_DATA;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                reg_gnt       = ~sel_pkt_q;
                pkt_gnt       = sel_pkt_q;
                ulpi_data_out = sel_pkt_q ? pkt_data : reg_wdata;
                if (ulpi_dir) begin
                    // PHY took the bus: no stp, and the byte did not go out.
                    abort   = 1'b1;
                    state_d = S_BUSY;
                end else if (ulpi_nxt) begin
                    if (!sel_pkt_q) begin
                        state_d = S_STOP;
                    end else if (pkt_valid) begin
                        pkt_rd = 1'b1;
                        if (pkt_last) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        state_d = S_ABORT;
                    end
                end
            end

            S_STOP: begin
                reg_gnt  = ~sel_pkt_q;
                pkt_gnt  = sel_pkt_q;
                ulpi_stp = 1'b1;
                reg_done = ~sel_pkt_q;
                pkt_done = sel_pkt_q;
                state_d  = ulpi_dir ? S_BUSY : S_TURN;
            end

            S_ABORT: begin
                // 0xFF with stp tells the PHY to discard the transfer.
                reg_gnt       = ~sel_pkt_q;
                pkt_gnt       = sel_pkt_q;
                ulpi_stp      = 1'b1;
                ulpi_data_out = 8'hFF;
                abort         = 1'b1;
                state_d       = ulpi_dir ? S_BUSY : S_TURN;
            end

            S_BUSY: begin
                if (!ulpi_dir) begin
                    state_d = S_TURN;
                end
            end

            S_TURN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
